// File: rtl/controle_mapa.sv
// Map-selection controller: debounced-edge buttons step a 2-bit map index, confirm locks it until game_over.
// Optional MAP_AUTOSCROLL_EN adds an idle auto-advance after AUTO_DIV quiet cycles.
module controle_mapa #(
    parameter int MAP_COUNT = 4,
    parameter int BLINK_DIV = 25_000_000,
    parameter int AUTO_DIV  = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_confirm,
    input  logic       game_over,
    output logic [1:0] sel,
    output logic       locked,
    output logic       start,
    output logic       preview_blink
);

    localparam int              CW            = $clog2(BLINK_DIV);
    localparam logic [1:0]      LP_LAST       = 2'(MAP_COUNT - 1);
    localparam logic [CW-1:0]   LP_BLINK_LAST = CW'(BLINK_DIV - 1);

    if (MAP_COUNT < 2 || MAP_COUNT > 4 || BLINK_DIV < 2 || AUTO_DIV < 2) begin : g_bad_param
        $error("controle_mapa: illegal parameter value");
    end

    typedef enum logic {
        ST_SELECT,
        ST_LOCKED
    } state_t;

    state_t          r_state;
    logic [1:0]      r_sel;
    logic            r_locked;
    logic            r_start;
    logic            r_blink;
    logic [CW-1:0]   r_cnt;

    // Bit order in every button vector: {confirm, prev, next}
    logic [2:0]      w_btn;
    logic [2:0]      r_s1;
    logic [2:0]      r_s2;
    logic [2:0]      r_s3;
    logic [2:0]      r_ev;

    logic            w_ev_next;
    logic            w_ev_prev;
    logic            w_ev_conf;
    logic            w_auto;
    logic            w_step_fwd;
    logic            w_step_back;
    logic            w_restart;

    assign w_btn = {btn_confirm, btn_prev, btn_next};

    // Registering the edge pulse puts the sel/locked update three edges after first sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
            r_ev <= '0;
        end else begin
            r_s1 <= w_btn;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            r_ev <= r_s2 & ~r_s3;
        end
    end

    assign w_ev_next = r_ev[0];
    assign w_ev_prev = r_ev[1];
    assign w_ev_conf = r_ev[2];

`ifdef MAP_AUTOSCROLL_EN
    localparam int            AW           = $clog2(AUTO_DIV);
    localparam logic [AW-1:0] LP_AUTO_LAST = AW'(AUTO_DIV - 1);

    logic [AW-1:0] r_idle;

    assign w_auto = (r_state == ST_SELECT) && !(|r_ev) && (r_idle == LP_AUTO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= '0;
        end else if (r_state != ST_SELECT || |r_ev || w_auto) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + AW'(1);
        end
    end
`else
    assign w_auto = 1'b0;
`endif

    assign w_step_fwd  = (w_ev_next & ~w_ev_prev) | w_auto;
    assign w_step_back = w_ev_prev & ~w_ev_next;
    assign w_restart   = w_ev_next | w_ev_prev | w_auto;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_SELECT;
            r_sel    <= '0;
            r_locked <= 1'b0;
            r_start  <= 1'b0;
            r_blink  <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_SELECT: begin
                    if (w_ev_conf) begin
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                        r_start  <= 1'b1;
                        r_cnt    <= '0;
                        r_blink  <= 1'b1;
                    end else begin
                        // Explicit wrap compare so MAP_COUNT < 4 never reaches unused indices
                        if (w_step_fwd) begin
                            r_sel <= (r_sel == LP_LAST) ? 2'd0 : r_sel + 2'd1;
                        end else if (w_step_back) begin
                            r_sel <= (r_sel == 2'd0) ? LP_LAST : r_sel - 2'd1;
                        end
                        if (w_restart) begin
                            r_cnt   <= '0;
                            r_blink <= 1'b1;
                        end else if (r_cnt == LP_BLINK_LAST) begin
                            r_cnt   <= '0;
                            r_blink <= ~r_blink;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    r_cnt   <= '0;
                    r_blink <= 1'b1;
                    if (game_over) begin
                        r_state  <= ST_SELECT;
                        r_locked <= 1'b0;
                    end
                end
                default: r_state <= ST_SELECT;
            endcase
        end
    end

    assign sel           = r_sel;
    assign locked        = r_locked;
    assign start         = r_start;
    assign preview_blink = r_blink;

endmodule

// File: tb/tb_controle_mapa.sv
// Bench for controle_mapa: two instances (4 and 3 maps) against a cycle model plus directed literal checks.
module tb_controle_mapa;

    localparam int BDIV = 4;
    localparam int ADIV = 8;
`ifdef MAP_AUTOSCROLL_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       bn = 1'b0;
    logic       bp = 1'b0;
    logic       bc = 1'b0;
    logic       go = 1'b0;
    logic [1:0] sel4, sel3;
    logic       lk4, st4, bl4, lk3, st3, bl3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    controle_mapa #(.MAP_COUNT(4), .BLINK_DIV(BDIV), .AUTO_DIV(ADIV)) dut4 (
        .clk(clk), .rst_n(rst_n), .btn_next(bn), .btn_prev(bp), .btn_confirm(bc),
        .game_over(go), .sel(sel4), .locked(lk4), .start(st4), .preview_blink(bl4)
    );

    controle_mapa #(.MAP_COUNT(3), .BLINK_DIV(BDIV), .AUTO_DIV(ADIV)) dut3 (
        .clk(clk), .rst_n(rst_n), .btn_next(bn), .btn_prev(bp), .btn_confirm(bc),
        .game_over(go), .sel(sel3), .locked(lk3), .start(st3), .preview_blink(bl3)
    );

    // Model: an input first sampled at edge N becomes an event acted on at edge N+3.
    typedef struct {
        bit [4:0] hn, hp, hc;
        bit       lk, st;
        int       sel, age, idle;
    } model_t;

    model_t m4, m3;

    function automatic model_t mreset();
        model_t m;
        m.hn = '0; m.hp = '0; m.hc = '0;
        m.lk = 1'b0; m.st = 1'b0;
        m.sel = 0; m.age = 0; m.idle = 0;
        return m;
    endfunction

    function automatic model_t mstep(model_t mi, int mc, bit in_n, bit in_p, bit in_c, bit in_go);
        model_t m;
        bit n, p, c, adv;
        m = mi;
        m.hn = {m.hn[3:0], in_n};
        m.hp = {m.hp[3:0], in_p};
        m.hc = {m.hc[3:0], in_c};
        n = m.hn[3] && !m.hn[4];
        p = m.hp[3] && !m.hp[4];
        c = m.hc[3] && !m.hc[4];
        m.st = 1'b0;
        if (m.lk) begin
            m.age = 0;
            m.idle = 0;
            if (in_go) m.lk = 1'b0;
        end else if (c) begin
            m.lk = 1'b1;
            m.st = 1'b1;
            m.age = 0;
            m.idle = 0;
        end else begin
            adv = AUTO_EN && !n && !p && (m.idle == ADIV - 1);
            if ((n && !p) || adv) m.sel = (m.sel + 1) % mc;
            else if (p && !n) m.sel = (m.sel + mc - 1) % mc;
            if (n || p || adv) begin
                m.age = 0;
                m.idle = 0;
            end else begin
                m.age = m.age + 1;
                m.idle = m.idle + 1;
            end
        end
        return m;
    endfunction

    function automatic bit mblink(model_t m);
        return m.lk || ((m.age / BDIV) % 2 == 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4 <= mreset();
            m3 <= mreset();
        end else begin
            m4 <= mstep(m4, 4, bn, bp, bc, go);
            m3 <= mstep(m3, 3, bn, bp, bc, go);
        end
    end

    task automatic cmp(string nm, logic [4:0] act, logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: sel/lk/st/bl got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("model4", {sel4, lk4, st4, bl4}, {2'(m4.sel), m4.lk, m4.st, mblink(m4)});
        cmp("model3", {sel3, lk3, st3, bl3}, {2'(m3.sel), m3.lk, m3.st, mblink(m3)});
    end

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse(bit n, bit p, bit c);
        bn = n; bp = p; bc = c;
        cyc(1);
        bn = 1'b0; bp = 1'b0; bc = 1'b0;
    endtask

    // Returns right after the edge where the event takes effect.
    task automatic press(bit n, bit p, bit c);
        pulse(n, p, c);
        cyc(3);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    int exp_sel [5] = '{1, 2, 3, 0, 1};
    int prev_sel;

    initial begin
        #1 rst_n = 1'b0;
        cyc(1);
        chk("reset_sel", sel4, 0);
        chk("reset_locked", lk4, 0);
        chk("reset_start", st4, 0);
        chk("reset_blink", bl4, 1);
        cyc(1);
        rst_n = 1'b1;
`ifndef MAP_AUTOSCROLL_EN
        cyc(3);
        chk("blink_age3", bl4, 1);
        cyc(1);
        chk("blink_age4", bl4, 0);
        cyc(4);
        chk("blink_age8", bl4, 1);

        prev_sel = 0;
        for (int i = 0; i < 5; i++) begin
            pulse(1'b1, 1'b0, 1'b0);
            cyc(2);
            chk("next_before", sel4, prev_sel);
            cyc(1);
            chk("next_after", sel4, exp_sel[i]);
            chk("next_locked", lk4, 0);
            chk("next_blink", bl4, 1);
            prev_sel = exp_sel[i];
        end
        cyc(12);
        chk("no_autoscroll", sel4, 1);

        do_reset();
        press(1'b0, 1'b1, 1'b0);
        chk("prev_wrap4", sel4, 3);
        chk("prev_wrap3", sel3, 2);
        press(1'b1, 1'b1, 1'b0);
        chk("next_prev_same", sel4, 3);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("sel_to_1", sel4, 1);

        pulse(1'b1, 1'b0, 1'b1);
        cyc(2);
        chk("confirm_before", lk4, 0);
        cyc(1);
        chk("confirm_locked", lk4, 1);
        chk("confirm_start", st4, 1);
        chk("confirm_sel", sel4, 1);
        cyc(1);
        chk("start_one_cycle", st4, 0);
        chk("still_locked", lk4, 1);

        go = 1'b1;
        cyc(1);
        go = 1'b0;
        chk("unlock", lk4, 0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk("locked_sel2", sel4, 2);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk("locked_ignores_sel", sel4, 2);
        chk("locked_ignores_lk", lk4, 1);
        cyc(10);
        chk("locked_blink", bl4, 1);

        bn = 1'b1;
        cyc(6);
        go = 1'b1;
        cyc(1);
        go = 1'b0;
        chk("go_release", lk4, 0);
        chk("go_keep_sel", sel4, 2);
        cyc(6);
        chk("held_no_event", sel4, 2);
        bn = 1'b0;
        cyc(2);
        go = 1'b1;
        cyc(3);
        go = 1'b0;
        chk("go_in_select", lk4, 0);

        cyc(5);
        press(1'b1, 1'b0, 1'b0);
        chk("restart_blink", bl4, 1);
        chk("restart_sel", sel4, 3);
        press(1'b0, 1'b0, 1'b1);
        cyc(2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_sel", sel4, 0);
        chk("async_locked", lk4, 0);
        chk("async_blink", bl4, 1);
        bn = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3);
        chk("held_reset_before", sel4, 0);
        cyc(1);
        chk("held_reset_event", sel4, 1);
        bn = 1'b0;
`else
        cyc(7);
        chk("auto_before", sel4, 0);
        cyc(1);
        chk("auto_first", sel4, 1);
        cyc(8);
        chk("auto_second", sel4, 2);
        cyc(3);
        #2 rst_n = 1'b0;
        #1;
        chk("auto_async_sel", sel4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(8);
        chk("auto_after_reset", sel4, 1);
        press(1'b1, 1'b0, 1'b0);
        chk("auto_next", sel4, 2);
        cyc(20);
`endif
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
